// File: rtl/ex_hazard_ctrl_v.sv
// EX-stage scheduler: decodes ID, shadows EX/MEM/WB destinations,
// decides issue/stall/flush, registers forwarding selects, counts stalls.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   isForw_ON        1 = forward results, 0 = resolve RAW hazards by stalling
//   id_valid         ID holds a real instruction
//   id_instr         RV32I instruction word in ID
//   ex_flush         taken branch/jump in EX: kill ID and EX contents
//   stall            combinational hold of PC and IF/ID
//   ex_valid, ex_op  registered EX occupancy and opcode (bubble = 0)
//   forwA, forwB     registered operand selects: 00 rf, 01 exmem, 10 memwb
//   stall_cnt        saturating count of stall cycles
module ex_hazard_ctrl_v #(
    parameter int         CNT_W   = 16,
    parameter logic [6:0] LOAD_OP = 7'b0000011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             isForw_ON,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [6:0]       ex_op,
    output logic [1:0]       forwA,
    output logic [1:0]       forwB,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    logic [6:0] id_op;
    logic [4:0] id_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_wr;
    logic       id_ld;
    logic       use_a;
    logic       use_b;

    // Shadow stage state
    logic             ex_valid_q,  ex_valid_d;
    logic [4:0]       ex_rd_q,     ex_rd_d;
    logic             ex_wr_q,     ex_wr_d;
    logic             ex_ld_q,     ex_ld_d;
    logic [6:0]       ex_op_q,     ex_op_d;
    logic [1:0]       forw_a_q,    forw_a_d;
    logic [1:0]       forw_b_q,    forw_b_d;
    logic             mem_valid_q, mem_valid_d;
    logic [4:0]       mem_rd_q,    mem_rd_d;
    logic             mem_wr_q,    mem_wr_d;
    logic             mem_ld_q,    mem_ld_d;
    logic             wb_valid_q,  wb_valid_d;
    logic [4:0]       wb_rd_q,     wb_rd_d;
    logic             wb_wr_q,     wb_wr_d;
    logic             wb_ld_q,     wb_ld_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic a_ex, a_mem, b_ex, b_mem;
    logic hazard;
    logic issue;

    always_comb begin
        id_op  = id_instr[6:0];
        id_rd  = id_instr[11:7];
        id_rs1 = id_instr[19:15];
        id_rs2 = id_instr[24:20];
        id_wr  = (id_op inside {OP_R, OP_I, OP_LD, LOAD_OP, OP_JAL,
                                OP_JALR, OP_LUI, OP_AUIPC})
                 && (id_rd != 5'd0);
        id_ld  = id_wr && (id_op == LOAD_OP);
        // x0 as a source is never a hazard, so fold it into "uses"
        use_a  = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL})
                 && (id_rs1 != 5'd0);
        use_b  = (id_op inside {OP_R, OP_ST, OP_BR})
                 && (id_rs2 != 5'd0);
    end

    // WB is skipped: the register file writes through
    always_comb begin
        a_ex  = use_a && ex_valid_q  && ex_wr_q  && (ex_rd_q  == id_rs1);
        a_mem = use_a && mem_valid_q && mem_wr_q && (mem_rd_q == id_rs1);
        b_ex  = use_b && ex_valid_q  && ex_wr_q  && (ex_rd_q  == id_rs2);
        b_mem = use_b && mem_valid_q && mem_wr_q && (mem_rd_q == id_rs2);
        if (isForw_ON) begin
            hazard = ex_ld_q && (a_ex || b_ex);
        end else begin
            hazard = a_ex || a_mem || b_ex || b_mem;
        end
        stall = !reset && id_valid && !ex_flush && hazard;
        issue = id_valid && !stall && !ex_flush;
    end

    // EX match wins: it carries the newest value
    function automatic logic [1:0] fsel(input logic on,
                                        input logic m_ex,
                                        input logic m_mem);
        logic [1:0] s;
        s = SEL_RF;
        if (on) begin
            priority case (1'b1)
                m_ex:    s = SEL_EXM;
                m_mem:   s = SEL_MWB;
                default: s = SEL_RF;
            endcase
        end
        return s;
    endfunction

    always_comb begin
        ex_valid_d  = issue;
        ex_rd_d     = issue ? id_rd : 5'd0;
        ex_wr_d     = issue && id_wr;
        ex_ld_d     = issue && id_ld;
        ex_op_d     = issue ? id_op : 7'd0;
        forw_a_d    = issue ? fsel(isForw_ON, a_ex, a_mem) : SEL_RF;
        forw_b_d    = issue ? fsel(isForw_ON, b_ex, b_mem) : SEL_RF;
        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;
        mem_ld_d    = ex_ld_q;
        wb_valid_d  = mem_valid_q;
        wb_rd_d     = mem_rd_q;
        wb_wr_d     = mem_wr_q;
        wb_ld_d     = mem_ld_q;
        cnt_d       = cnt_q;
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_op_q     <= 7'd0;
            forw_a_q    <= SEL_RF;
            forw_b_q    <= SEL_RF;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_wr_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_wr_q     <= 1'b0;
            wb_ld_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_ld_q     <= ex_ld_d;
            ex_op_q     <= ex_op_d;
            forw_a_q    <= forw_a_d;
            forw_b_q    <= forw_b_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_ld_q    <= mem_ld_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
            wb_ld_q     <= wb_ld_d;
            cnt_q       <= cnt_d;
        end
    end

    // WB shadow and funct/imm bits do not steer any decision here
    logic unused_bits;
    assign unused_bits = ^{id_instr[31:25], id_instr[14:12], mem_ld_q,
                           wb_valid_q, wb_rd_q, wb_wr_q, wb_ld_q};

    assign ex_valid  = ex_valid_q;
    assign ex_op     = ex_op_q;
    assign forwA     = forw_a_q;
    assign forwB     = forw_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl_v.sv
// Directed bench for ex_hazard_ctrl_v: forwarding, load-use,
// forwarding-off stalls, flush, reset mid-stall, counter saturation.
module tb_ex_hazard_ctrl_v;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          isForw_ON;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic          ex_flush;
    logic          stall;
    logic          ex_valid;
    logic [6:0]    ex_op;
    logic [1:0]    forwA;
    logic [1:0]    forwB;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    ex_hazard_ctrl_v #(.CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .isForw_ON (isForw_ON),
        .id_valid  (id_valid),
        .id_instr  (id_instr),
        .ex_flush  (ex_flush),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op),
        .forwA     (forwA),
        .forwB     (forwB),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [6:0] f7,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd,
                                       input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins);
        id_valid = v;
        id_instr = ins;
        #1;
    endtask

    task automatic do_reset(input logic fwd);
        reset     = 1'b1;
        isForw_ON = fwd;
        ex_flush  = 1'b0;
        drive(1'b0, NOP);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        isForw_ON = 1'b1;
        ex_flush  = 1'b0;
        drive(1'b1, rtype(7'd0, 5'd6, 5'd5, 5'd1));
        tick();
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_op !== 7'd0) begin
            errors++;
            $display("FAIL rst_ex got v=%0b op=%0h want v=0 op=0",
                     ex_valid, ex_op);
        end
        checks++;
        if (forwA !== 2'b00 || forwB !== 2'b00 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL rst_fw got a=%0b b=%0b cnt=%0d want 0 0 0",
                     forwA, forwB, stall_cnt);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall got %0b want 0", stall);
        end
        reset = 1'b0;
        drive(1'b0, NOP);
    endtask

    task automatic test_fwd_ex();
        do_reset(1'b1);
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd5, 5'd1));
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL fex_stall got %0b want 0", stall);
        end
        tick();
        drive(1'b0, NOP);
        checks++;
        if (ex_valid !== 1'b1 || ex_op !== 7'b0110011) begin
            errors++;
            $display("FAIL fex_ex got v=%0b op=%0h want v=1 op=33",
                     ex_valid, ex_op);
        end
        checks++;
        if (forwA !== 2'b01 || forwB !== 2'b00 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL fex_sel got a=%0b b=%0b cnt=%0d want 01 00 0",
                     forwA, forwB, stall_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset(1'b1);
        drive(1'b1, lw(5'd5, 5'd1));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd1, 5'd5));
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall1 got %0b want 1", stall);
        end
        tick();
        #1;
        checks++;
        if (ex_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble got v=%0b stall=%0b want 0 0",
                     ex_valid, stall);
        end
        tick();
        drive(1'b0, NOP);
        checks++;
        if (ex_valid !== 1'b1 || forwA !== 2'b00 || forwB !== 2'b10) begin
            errors++;
            $display("FAIL lu_sel got v=%0b a=%0b b=%0b want 1 00 10",
                     ex_valid, forwA, forwB);
        end
        checks++;
        if (stall_cnt !== 1) begin
            errors++;
            $display("FAIL lu_cnt got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_fwd_mem();
        do_reset(1'b1);
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, NOP);
        tick();
        drive(1'b1, rtype(7'b0100000, 5'd7, 5'd5, 5'd5));
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL fmem_stall got %0b want 0", stall);
        end
        tick();
        checks++;
        if (forwA !== 2'b10 || forwB !== 2'b10) begin
            errors++;
            $display("FAIL fmem_sel got a=%0b b=%0b want 10 10",
                     forwA, forwB);
        end
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd5, 5'd1));
        tick();
        drive(1'b0, NOP);
        checks++;
        if (forwA !== 2'b01 || forwB !== 2'b00) begin
            errors++;
            $display("FAIL fprio_sel got a=%0b b=%0b want 01 00",
                     forwA, forwB);
        end
    endtask

    task automatic test_no_fwd();
        do_reset(1'b0);
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd5, 5'd0));
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL nf_stall1 got %0b want 1", stall);
        end
        tick();
        #1;
        checks++;
        if (stall !== 1'b1 || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL nf_stall2 got s=%0b v=%0b want 1 0",
                     stall, ex_valid);
        end
        tick();
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL nf_stall3 got %0b want 0", stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || forwA !== 2'b00 || stall_cnt !== 2) begin
            errors++;
            $display("FAIL nf_issue got v=%0b a=%0b cnt=%0d want 1 00 2",
                     ex_valid, forwA, stall_cnt);
        end
        drive(1'b1, rtype(7'd0, 5'd0, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd0, 5'd1));
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL nf_x0 got %0b want 0", stall);
        end
        tick();
        drive(1'b0, NOP);
        checks++;
        if (stall_cnt !== 2) begin
            errors++;
            $display("FAIL nf_x0cnt got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_flush();
        do_reset(1'b1);
        drive(1'b1, lw(5'd5, 5'd1));
        tick();
        ex_flush = 1'b1;
        drive(1'b1, rtype(7'd0, 5'd6, 5'd1, 5'd5));
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL fl_stall got %0b want 0", stall);
        end
        tick();
        ex_flush = 1'b0;
        drive(1'b0, NOP);
        checks++;
        if (ex_valid !== 1'b0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL fl_ex got v=%0b cnt=%0d want 0 0",
                     ex_valid, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset(1'b0);
        drive(1'b1, rtype(7'd0, 5'd5, 5'd1, 5'd2));
        tick();
        drive(1'b1, rtype(7'd0, 5'd6, 5'd5, 5'd0));
        tick();
        #1;
        checks++;
        if (stall !== 1'b1 || stall_cnt !== 1) begin
            errors++;
            $display("FAIL rm_pre got s=%0b cnt=%0d want 1 1",
                     stall, stall_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rm_force got %0b want 0", stall);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || ex_valid !== 1'b0 || stall_cnt !== 0) begin
            errors++;
            $display("FAIL rm_post got s=%0b v=%0b cnt=%0d want 0 0 0",
                     stall, ex_valid, stall_cnt);
        end
        checks++;
        if (forwA !== 2'b00 || forwB !== 2'b00) begin
            errors++;
            $display("FAIL rm_sel got a=%0b b=%0b want 00 00",
                     forwA, forwB);
        end
        drive(1'b0, NOP);
    endtask

    task automatic test_saturate();
        logic          cur;
        logic          s;
        int            nst;
        logic [CW-1:0] top;
        top = '1;
        do_reset(1'b0);
        cur = 1'b0;
        for (int i = 0; i < 300 && stall_cnt !== top; i++) begin
            drive(1'b1, cur ? rtype(7'd0, 5'd6, 5'd5, 5'd0)
                            : rtype(7'd0, 5'd5, 5'd6, 5'd0));
            s = stall;
            tick();
            if (!s) cur = ~cur;
        end
        checks++;
        if (stall_cnt !== top) begin
            errors++;
            $display("FAIL sat_reach got %0d want %0d", stall_cnt, top);
        end
        nst = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, cur ? rtype(7'd0, 5'd6, 5'd5, 5'd0)
                            : rtype(7'd0, 5'd5, 5'd6, 5'd0));
            s = stall;
            if (s) nst++;
            tick();
            if (!s) cur = ~cur;
        end
        drive(1'b0, NOP);
        checks++;
        if (nst < 1 || stall_cnt !== top) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d stalls=%0d want %0d >=1",
                     stall_cnt, nst, top);
        end
    endtask

    initial begin
        reset     = 1'b1;
        isForw_ON = 1'b1;
        id_valid  = 1'b0;
        id_instr  = NOP;
        ex_flush  = 1'b0;
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_fwd_mem();
        test_no_fwd();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
